// File: rtl/nv_nvdla_sdp2pdp_pack.sv
// Packs the sdp2pdp element stream into PACK_N-element PDP words; latency 1 cycle, partial word flushed at line end.
// Backpressure: non-completing elements always accepted; completing element waits for free/draining output. Optional stall counter: NVDLA_SDP2PDP_PERF_EN.
module nv_nvdla_sdp2pdp_pack #(
    parameter int PACK_N = 4,
    parameter int ELEM_W = 8,
    parameter int LINE_W = 13
) (
    input  logic                       nvdla_core_clk,
    input  logic                       nvdla_core_rst,
    input  logic [LINE_W-1:0]          cfg_line_width,
    input  logic                       sdp2pdp_valid,
    output logic                       sdp2pdp_ready,
    input  logic [ELEM_W-1:0]          sdp2pdp_pd,
    output logic                       pdp_in_valid,
    input  logic                       pdp_in_ready,
    output logic [PACK_N*ELEM_W-1:0]   pdp_in_pd,
    output logic [PACK_N-1:0]          pdp_in_mask,
    output logic                       pdp_in_eol,
    output logic [31:0]                perf_stall_cnt
);
    localparam int PK_W   = (PACK_N > 1) ? $clog2(PACK_N) : 1;
    localparam int WORD_W = PACK_N * ELEM_W;

    logic [PK_W-1:0]                 pk_cnt_q, pk_cnt_d;
    logic [LINE_W-1:0]               el_cnt_q, el_cnt_d;
    logic [PACK_N-1:0][ELEM_W-1:0]   pk_dat_q, pk_dat_d;
    logic                            out_vld_q, out_vld_d;
    logic [WORD_W-1:0]               out_pd_q, out_pd_d;
    logic [PACK_N-1:0]               out_mask_q, out_mask_d;
    logic                            out_eol_q, out_eol_d;

    logic                            line_end, cand, accept, complete;
    logic [PACK_N-1:0][ELEM_W-1:0]   word;
    logic [PACK_N-1:0]               word_mask;

    assign line_end      = (el_cnt_q == cfg_line_width);
    assign cand          = (pk_cnt_q == PK_W'(PACK_N - 1)) | line_end;
    assign sdp2pdp_ready = ~nvdla_core_rst & (~cand | ~out_vld_q | pdp_in_ready);
    assign accept        = sdp2pdp_valid & sdp2pdp_ready;
    assign complete      = accept & cand;

    // Outgoing word: held slots below pk_cnt, the incoming element at pk_cnt, zeros above.
    always_comb begin
        word      = '0;
        word_mask = '0;
        for (int i = 0; i < PACK_N; i++) begin
            if (PK_W'(i) < pk_cnt_q) begin
                word[i]      = pk_dat_q[i];
                word_mask[i] = 1'b1;
            end else if (PK_W'(i) == pk_cnt_q) begin
                word[i]      = sdp2pdp_pd;
                word_mask[i] = 1'b1;
            end
        end
    end

    always_comb begin
        pk_cnt_d   = pk_cnt_q;
        el_cnt_d   = el_cnt_q;
        pk_dat_d   = pk_dat_q;
        out_vld_d  = out_vld_q;
        out_pd_d   = out_pd_q;
        out_mask_d = out_mask_q;
        out_eol_d  = out_eol_q;
        if (accept) begin
            pk_dat_d[pk_cnt_q] = sdp2pdp_pd;
            pk_cnt_d           = cand ? '0 : pk_cnt_q + 1'b1;
            el_cnt_d           = line_end ? '0 : el_cnt_q + 1'b1;
        end
        // A load in the same cycle as a drain keeps valid high with the new word.
        if (complete) begin
            out_vld_d  = 1'b1;
            out_pd_d   = word;
            out_mask_d = word_mask;
            out_eol_d  = line_end;
        end else if (pdp_in_ready) begin
            out_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            pk_cnt_q   <= '0;
            el_cnt_q   <= '0;
            pk_dat_q   <= '0;
            out_vld_q  <= 1'b0;
            out_pd_q   <= '0;
            out_mask_q <= '0;
            out_eol_q  <= 1'b0;
        end else begin
            pk_cnt_q   <= pk_cnt_d;
            el_cnt_q   <= el_cnt_d;
            pk_dat_q   <= pk_dat_d;
            out_vld_q  <= out_vld_d;
            out_pd_q   <= out_pd_d;
            out_mask_q <= out_mask_d;
            out_eol_q  <= out_eol_d;
        end
    end

    assign pdp_in_valid = out_vld_q;
    assign pdp_in_pd    = out_pd_q;
    assign pdp_in_mask  = out_mask_q;
    assign pdp_in_eol   = out_eol_q;

`ifdef NVDLA_SDP2PDP_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            stall_cnt_q <= '0;
        end else if (out_vld_q & ~pdp_in_ready & ~(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
`else
    assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_nv_nvdla_sdp2pdp_pack.sv
// Directed bench for nv_nvdla_sdp2pdp_pack (PACK_N=4, ELEM_W=8).
module tb_nv_nvdla_sdp2pdp_pack;
    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] cfg_line_width;
    logic        sdp2pdp_valid;
    logic        sdp2pdp_ready;
    logic [7:0]  sdp2pdp_pd;
    logic        pdp_in_valid;
    logic        pdp_in_ready;
    logic [31:0] pdp_in_pd;
    logic [3:0]  pdp_in_mask;
    logic        pdp_in_eol;
    logic [31:0] perf_stall_cnt;

    int checks = 0;
    int errors = 0;

`ifdef NVDLA_SDP2PDP_PERF_EN
    localparam logic [31:0] EXP_STALL = 32'd10;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
`endif

    always #5 clk = ~clk;

    nv_nvdla_sdp2pdp_pack dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .cfg_line_width (cfg_line_width),
        .sdp2pdp_valid  (sdp2pdp_valid),
        .sdp2pdp_ready  (sdp2pdp_ready),
        .sdp2pdp_pd     (sdp2pdp_pd),
        .pdp_in_valid   (pdp_in_valid),
        .pdp_in_ready   (pdp_in_ready),
        .pdp_in_pd      (pdp_in_pd),
        .pdp_in_mask    (pdp_in_mask),
        .pdp_in_eol     (pdp_in_eol),
        .perf_stall_cnt (perf_stall_cnt)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        sdp2pdp_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Offers one element for one cycle; returns after the following posedge (+1).
    task automatic send_elem(input logic [7:0] d);
        @(negedge clk);
        sdp2pdp_valid = 1'b1;
        sdp2pdp_pd    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        sdp2pdp_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({pdp_in_valid, pdp_in_pd, pdp_in_mask, pdp_in_eol, sdp2pdp_ready} !== 39'd0 || perf_stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: vld=%b pd=%h mask=%h eol=%b rdy=%b perf=%0d, want all 0",
                     pdp_in_valid, pdp_in_pd, pdp_in_mask, pdp_in_eol, sdp2pdp_ready, perf_stall_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (sdp2pdp_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b want 1", sdp2pdp_ready);
        end
    endtask

    task automatic test_full_line();
        cfg_line_width = 13'd7;
        pdp_in_ready   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sdp2pdp_valid = 1'b1;
            sdp2pdp_pd    = 8'(i + 1);
            #1;
            checks++;
            if (sdp2pdp_ready !== 1'b1) begin
                errors++;
                $display("FAIL full_ready[%0d]: got %b want 1", i, sdp2pdp_ready);
            end
            @(posedge clk);
            #1;
            if (i == 3) begin
                checks++;
                if (pdp_in_valid !== 1'b1 || pdp_in_pd !== 32'h04030201 || pdp_in_mask !== 4'hF || pdp_in_eol !== 1'b0) begin
                    errors++;
                    $display("FAIL full_word1: vld=%b pd=%h mask=%h eol=%b want 1 04030201 f 0",
                             pdp_in_valid, pdp_in_pd, pdp_in_mask, pdp_in_eol);
                end
            end else if (i == 7) begin
                checks++;
                if (pdp_in_valid !== 1'b1 || pdp_in_pd !== 32'h08070605 || pdp_in_mask !== 4'hF || pdp_in_eol !== 1'b1) begin
                    errors++;
                    $display("FAIL full_word2: vld=%b pd=%h mask=%h eol=%b want 1 08070605 f 1",
                             pdp_in_valid, pdp_in_pd, pdp_in_mask, pdp_in_eol);
                end
            end else begin
                checks++;
                if (pdp_in_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL full_novalid[%0d]: got %b want 0", i, pdp_in_valid);
                end
            end
        end
        idle_cycle();
        checks++;
        if (pdp_in_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_drained: vld=%b want 0", pdp_in_valid);
        end
    endtask

    task automatic test_partial_line();
        cfg_line_width = 13'd5;
        pdp_in_ready   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_elem(8'hA0 + 8'(i));
            if (i == 3) begin
                checks++;
                if (pdp_in_valid !== 1'b1 || pdp_in_pd !== 32'hA3A2A1A0 || pdp_in_mask !== 4'hF || pdp_in_eol !== 1'b0) begin
                    errors++;
                    $display("FAIL partial_word1: vld=%b pd=%h mask=%h eol=%b want 1 a3a2a1a0 f 0",
                             pdp_in_valid, pdp_in_pd, pdp_in_mask, pdp_in_eol);
                end
            end
        end
        checks++;
        if (pdp_in_valid !== 1'b1 || pdp_in_pd !== 32'h0000A5A4 || pdp_in_mask !== 4'h3 || pdp_in_eol !== 1'b1) begin
            errors++;
            $display("FAIL partial_word2: vld=%b pd=%h mask=%h eol=%b want 1 0000a5a4 3 1",
                     pdp_in_valid, pdp_in_pd, pdp_in_mask, pdp_in_eol);
        end
        // A single-element line shows the next element lands in slot 0.
        cfg_line_width = 13'd0;
        send_elem(8'hB0);
        checks++;
        if (pdp_in_valid !== 1'b1 || pdp_in_pd !== 32'h000000B0 || pdp_in_mask !== 4'h1 || pdp_in_eol !== 1'b1) begin
            errors++;
            $display("FAIL partial_newline: vld=%b pd=%h mask=%h eol=%b want 1 000000b0 1 1",
                     pdp_in_valid, pdp_in_pd, pdp_in_mask, pdp_in_eol);
        end
        idle_cycle();
    endtask

    task automatic test_line_width0();
        cfg_line_width = 13'd0;
        pdp_in_ready   = 1'b1;
        send_elem(8'h11);
        checks++;
        if (pdp_in_valid !== 1'b1 || pdp_in_pd !== 32'h00000011 || pdp_in_mask !== 4'h1 || pdp_in_eol !== 1'b1) begin
            errors++;
            $display("FAIL lw0_word1: vld=%b pd=%h mask=%h eol=%b want 1 00000011 1 1",
                     pdp_in_valid, pdp_in_pd, pdp_in_mask, pdp_in_eol);
        end
        send_elem(8'h22);
        checks++;
        if (pdp_in_valid !== 1'b1 || pdp_in_pd !== 32'h00000022 || pdp_in_mask !== 4'h1 || pdp_in_eol !== 1'b1) begin
            errors++;
            $display("FAIL lw0_word2: vld=%b pd=%h mask=%h eol=%b want 1 00000022 1 1",
                     pdp_in_valid, pdp_in_pd, pdp_in_mask, pdp_in_eol);
        end
        idle_cycle();
    endtask

    // Output stalled for cycles 0..13; cycle 14 drains word 1 while word 2 loads.
    task automatic test_stall_back_to_back();
        int   ptr;
        logic acc;
        do_reset();
        cfg_line_width = 13'd7;
        ptr = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            pdp_in_ready  = (cyc >= 14);
            sdp2pdp_valid = (ptr < 8);
            sdp2pdp_pd    = 8'(ptr + 1);
            #1;
            if (cyc >= 7 && cyc <= 13) begin
                checks++;
                if (sdp2pdp_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_rdy_low[%0d]: got %b want 0", cyc, sdp2pdp_ready);
                end
            end else if (cyc >= 4 && cyc <= 6 || cyc == 14) begin
                checks++;
                if (sdp2pdp_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_rdy_high[%0d]: got %b want 1", cyc, sdp2pdp_ready);
                end
            end
            acc = sdp2pdp_valid & sdp2pdp_ready;
            @(posedge clk);
            #1;
            if (acc) ptr++;
            if (cyc >= 4 && cyc <= 13) begin
                checks++;
                if (pdp_in_valid !== 1'b1 || pdp_in_pd !== 32'h04030201 || pdp_in_mask !== 4'hF || pdp_in_eol !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_hold[%0d]: vld=%b pd=%h mask=%h eol=%b want 1 04030201 f 0",
                             cyc, pdp_in_valid, pdp_in_pd, pdp_in_mask, pdp_in_eol);
                end
            end
            if (cyc == 13) begin
                checks++;
                if (ptr !== 7) begin
                    errors++;
                    $display("FAIL stall_accepted: got %0d elements want 7", ptr);
                end
            end
            if (cyc == 14) begin
                checks++;
                if (pdp_in_valid !== 1'b1 || pdp_in_pd !== 32'h08070605 || pdp_in_mask !== 4'hF || pdp_in_eol !== 1'b1) begin
                    errors++;
                    $display("FAIL drain_load: vld=%b pd=%h mask=%h eol=%b want 1 08070605 f 1",
                             pdp_in_valid, pdp_in_pd, pdp_in_mask, pdp_in_eol);
                end
            end
        end
        checks++;
        if (pdp_in_valid !== 1'b0 || ptr !== 8) begin
            errors++;
            $display("FAIL stall_end: vld=%b elems=%0d want 0 8", pdp_in_valid, ptr);
        end
        checks++;
        if (perf_stall_cnt !== EXP_STALL) begin
            errors++;
            $display("FAIL perf_stall_cnt: got %0d want %0d", perf_stall_cnt, EXP_STALL);
        end
    endtask

    task automatic test_reset_midline();
        do_reset();
        cfg_line_width = 13'd7;
        pdp_in_ready   = 1'b0;
        for (int i = 0; i < 6; i++) send_elem(8'h21 + 8'(i));
        checks++;
        if (pdp_in_valid !== 1'b1 || pdp_in_pd !== 32'h24232221) begin
            errors++;
            $display("FAIL pre_reset_word: vld=%b pd=%h want 1 24232221", pdp_in_valid, pdp_in_pd);
        end
        @(negedge clk);
        sdp2pdp_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({pdp_in_valid, pdp_in_pd, pdp_in_mask, pdp_in_eol, sdp2pdp_ready} !== 39'd0 || perf_stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL midline_reset: vld=%b pd=%h mask=%h eol=%b rdy=%b perf=%0d want all 0",
                     pdp_in_valid, pdp_in_pd, pdp_in_mask, pdp_in_eol, sdp2pdp_ready, perf_stall_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        pdp_in_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_elem(8'h31 + 8'(i));
        checks++;
        if (pdp_in_valid !== 1'b1 || pdp_in_pd !== 32'h34333231 || pdp_in_mask !== 4'hF || pdp_in_eol !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_word: vld=%b pd=%h mask=%h eol=%b want 1 34333231 f 0",
                     pdp_in_valid, pdp_in_pd, pdp_in_mask, pdp_in_eol);
        end
        idle_cycle();
    endtask

    initial begin
        rst            = 1'b0;
        cfg_line_width = 13'd7;
        sdp2pdp_valid  = 1'b0;
        sdp2pdp_pd     = 8'd0;
        pdp_in_ready   = 1'b1;
        test_reset();
        test_full_line();
        test_partial_line();
        test_line_width0();
        test_stall_back_to_back();
        test_reset_midline();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
